// File: rtl/pipeline_hazard_scoreboard_if.sv
// rtl/pipeline_hazard_scoreboard_if.sv - decode/datapath bundle for the hazard scoreboard
interface pipeline_hazard_scoreboard_if #(
   parameter int XLEN     = 32,
   parameter int REG_AW   = 5,
   parameter int STAGES   = 3,
   parameter int RD_PORTS = 2
);
   localparam int SELW = $clog2(STAGES + 1);

   logic                         dec_valid;
   logic [RD_PORTS*REG_AW-1:0]   dec_src;
   logic [RD_PORTS-1:0]          dec_src_used;
   logic [REG_AW-1:0]            dec_dst;
   logic                         dec_reg_write;
   logic                         dec_is_load;
   logic                         dec_is_branch;
   logic                         flush_in;
   logic [RD_PORTS*XLEN-1:0]     rf_data;
   logic [STAGES*XLEN-1:0]       stage_data;
   logic                         stall;
   logic [RD_PORTS*SELW-1:0]     fwd_sel;
   logic [RD_PORTS*XLEN-1:0]     fwd_data;
   logic [STAGES-1:0]            sb_valid;
   logic [31:0]                  stall_cnt;

   modport master (
      output dec_valid, dec_src, dec_src_used, dec_dst, dec_reg_write,
             dec_is_load, dec_is_branch, flush_in, rf_data, stage_data,
      input  stall, fwd_sel, fwd_data, sb_valid, stall_cnt
   );

   modport slave (
      input  dec_valid, dec_src, dec_src_used, dec_dst, dec_reg_write,
             dec_is_load, dec_is_branch, flush_in, rf_data, stage_data,
      output stall, fwd_sel, fwd_data, sb_valid, stall_cnt
   );
endinterface

// File: rtl/pipeline_hazard_scoreboard.sv
// rtl/pipeline_hazard_scoreboard.sv - in-flight write scoreboard, operand forwarding and stall generation
// Define HAZARD_EARLY_BRANCH_FWD_EN to let branches forward straight from stage 1.
module pipeline_hazard_scoreboard #(
   parameter int XLEN       = 32,
   parameter int REG_AW     = 5,
   parameter int STAGES     = 3,
   parameter int RD_PORTS   = 2,
   parameter int LOAD_READY = 2
) (
   input logic                        clk,
   input logic                        rst,
   pipeline_hazard_scoreboard_if.slave hz
);
   localparam int SELW = $clog2(STAGES + 1);

   // Entry k of the pipeline lives at index k-1
   logic [STAGES-1:0] sbValid;
   logic [STAGES-1:0] sbWr;
   logic [STAGES-1:0] sbLoad;
   logic [REG_AW-1:0] sbDst [STAGES];
   logic [31:0]       stallCnt;
   logic [RD_PORTS-1:0] portBlocked;
   logic              stallInt;
   logic              newValid;

   for (genvar p = 0; p < RD_PORTS; p++) begin : g_port
      logic [REG_AW-1:0] src;
      logic [SELW-1:0]   sel;
      logic              blocked;
      logic [XLEN-1:0]   data;

      assign src = hz.dec_src[p*REG_AW +: REG_AW];

      // Walk oldest to youngest so the youngest match is the one that sticks
      always_comb begin
         sel     = '0;
         blocked = 1'b0;
         for (int k = STAGES; k >= 1; k--) begin
            if (sbValid[k-1] && sbWr[k-1] && (sbDst[k-1] == src) &&
                (src != '0) && hz.dec_src_used[p]) begin
               sel     = SELW'(k);
               blocked = sbLoad[k-1] && (k < LOAD_READY);
`ifndef HAZARD_EARLY_BRANCH_FWD_EN
               if (hz.dec_is_branch && (k == 1))
                  blocked = 1'b1;
`endif
            end
         end
      end

      always_comb begin
         data = hz.rf_data[p*XLEN +: XLEN];
         for (int k = 1; k <= STAGES; k++) begin
            if (sel == SELW'(k))
               data = hz.stage_data[(k-1)*XLEN +: XLEN];
         end
      end

      assign portBlocked[p]                  = blocked;
      assign hz.fwd_sel[p*SELW +: SELW]      = sel;
      assign hz.fwd_data[p*XLEN +: XLEN]     = data;
   end

   assign stallInt  = hz.dec_valid && !hz.flush_in && (|portBlocked);
   assign newValid  = hz.dec_valid && !hz.flush_in && !stallInt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sbValid  <= '0;
         sbWr     <= '0;
         sbLoad   <= '0;
         stallCnt <= '0;
         for (int k = 0; k < STAGES; k++)
            sbDst[k] <= '0;
      end else begin
         sbValid <= {sbValid[STAGES-2:0], newValid};
         sbWr    <= {sbWr[STAGES-2:0], hz.dec_reg_write};
         sbLoad  <= {sbLoad[STAGES-2:0], hz.dec_is_load};
         for (int k = STAGES-1; k >= 1; k--)
            sbDst[k] <= sbDst[k-1];
         sbDst[0] <= hz.dec_dst;
         if (stallInt && (stallCnt != 32'hFFFF_FFFF))
            stallCnt <= stallCnt + 32'd1;
      end
   end

   assign hz.stall     = stallInt;
   assign hz.sb_valid  = sbValid;
   assign hz.stall_cnt = stallCnt;
endmodule

// File: tb/tb_pipeline_hazard_scoreboard.sv
// tb/tb_pipeline_hazard_scoreboard.sv - directed bench for pipeline_hazard_scoreboard
module tb_pipeline_hazard_scoreboard;
   localparam int XLEN       = 32;
   localparam int REG_AW     = 5;
   localparam int STAGES     = 3;
   localparam int RD_PORTS   = 2;
   localparam int LOAD_READY = 2;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   int          nErr = 0;
   int          nChk = 0;
   logic [31:0] expCnt;

   always #5 clk = ~clk;

   pipeline_hazard_scoreboard_if #(
      .XLEN(XLEN), .REG_AW(REG_AW), .STAGES(STAGES), .RD_PORTS(RD_PORTS)
   ) hz ();

   pipeline_hazard_scoreboard #(
      .XLEN(XLEN), .REG_AW(REG_AW), .STAGES(STAGES), .RD_PORTS(RD_PORTS),
      .LOAD_READY(LOAD_READY)
   ) dut (
      .clk(clk),
      .rst(rst),
      .hz(hz)
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      nChk++;
      assert (obs === exp) else begin
         nErr++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic drive(input logic v, input logic [4:0] dst, input logic wr, input logic ld,
                        input logic br, input logic [4:0] s0, input logic [4:0] s1,
                        input logic [1:0] used);
      hz.dec_valid     = v;
      hz.dec_dst       = dst;
      hz.dec_reg_write = wr;
      hz.dec_is_load   = ld;
      hz.dec_is_branch = br;
      hz.dec_src       = {s1, s0};
      hz.dec_src_used  = used;
   endtask

   initial begin
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      hz.flush_in   = 1'b0;
      hz.rf_data    = {32'hB1, 32'hA0};
      hz.stage_data = {32'h33, 32'h22, 32'h11};
      expCnt        = 32'd0;

      @(negedge clk); #1;
      chk("reset_sb_valid", hz.sb_valid, 3'b000);
      chk("reset_stall", hz.stall, 1'b0);
      chk("reset_stall_cnt", hz.stall_cnt, 32'd0);
      chk("reset_fwd_sel", hz.fwd_sel, 4'b0000);
      rst = 1'b0;

      // add r3
      @(negedge clk); drive(1'b1, 5'd3, 1'b1, 1'b0, 1'b0, 5'd1, 5'd2, 2'b11); #1;
      chk("nofwd_sel", hz.fwd_sel, 4'b0000);
      chk("nofwd_data", hz.fwd_data, {32'hB1, 32'hA0});
      // sub r6 <- r3, r0
      @(negedge clk); drive(1'b1, 5'd6, 1'b1, 1'b0, 1'b0, 5'd3, 5'd0, 2'b11); #1;
      chk("alu_fwd_stall", hz.stall, 1'b0);
      chk("alu_fwd_sel", hz.fwd_sel, 4'b0001);
      chk("alu_fwd_data", hz.fwd_data, {32'hB1, 32'h11});
      // lw r5
      @(negedge clk); drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd7, 5'd8, 2'b11); #1;
      chk("lw_stall", hz.stall, 1'b0);
      // add r9 <- r5, r3
      @(negedge clk); drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd5, 5'd3, 2'b11); #1;
      chk("loaduse_stall", hz.stall, 1'b1);
      chk("loaduse_sel_stalled", hz.fwd_sel, 4'b1101);
      expCnt = expCnt + 32'd1;
      @(negedge clk); #1;
      chk("loaduse_bubble", hz.sb_valid, 3'b110);
      chk("loaduse_release", hz.stall, 1'b0);
      chk("loaduse_sel", hz.fwd_sel, 4'b0010);
      chk("loaduse_data", hz.fwd_data, {32'hB1, 32'h22});
      chk("loaduse_cnt", hz.stall_cnt, expCnt);

      // r4 at stages 3 and 1, r0 writer at stage 2
      @(negedge clk); drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      @(negedge clk); drive(1'b1, 5'd0, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      @(negedge clk); drive(1'b1, 5'd4, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      @(negedge clk); drive(1'b1, 5'd11, 1'b1, 1'b0, 1'b0, 5'd4, 5'd0, 2'b11); #1;
      chk("youngest_sel", hz.fwd_sel, 4'b0001);
      chk("youngest_stall", hz.stall, 1'b0);
      chk("youngest_data", hz.fwd_data, {32'hB1, 32'h11});
      @(negedge clk); drive(1'b1, 5'd12, 1'b1, 1'b0, 1'b0, 5'd4, 5'd0, 2'b00); #1;
      chk("unused_port_sel", hz.fwd_sel, 4'b0000);

      // branch behind ALU producer
      repeat (3) begin
         @(negedge clk); drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      end
      @(negedge clk); drive(1'b1, 5'd2, 1'b1, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      @(negedge clk); drive(1'b1, 5'd0, 1'b0, 1'b0, 1'b1, 5'd2, 5'd0, 2'b11); #1;
`ifdef HAZARD_EARLY_BRANCH_FWD_EN
      chk("branch_stall", hz.stall, 1'b0);
      chk("branch_sel", hz.fwd_sel, 4'b0001);
      chk("branch_data", hz.fwd_data, {32'hB1, 32'h11});
`else
      chk("branch_stall", hz.stall, 1'b1);
      expCnt = expCnt + 32'd1;
      @(negedge clk); #1;
      chk("branch_release", hz.stall, 1'b0);
      chk("branch_sel", hz.fwd_sel, 4'b0010);
      chk("branch_data", hz.fwd_data, {32'hB1, 32'h22});
`endif
      chk("branch_cnt", hz.stall_cnt, expCnt);

      // load hazard killed by flush
      repeat (3) begin
         @(negedge clk); drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);
      end
      @(negedge clk); drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
      @(negedge clk); drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 2'b11);
      hz.flush_in = 1'b1; #1;
      chk("flush_stall", hz.stall, 1'b0);
      @(negedge clk); hz.flush_in = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00); #1;
      chk("flush_bubble", hz.sb_valid, 3'b010);
      chk("flush_cnt", hz.stall_cnt, expCnt);

      // asynchronous reset in the middle of a stall
      @(negedge clk); drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
      @(negedge clk); drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 2'b11); #1;
      chk("pre_rst_stall", hz.stall, 1'b1);
      #1 rst = 1'b1;
      #1;
      chk("rst_sb_valid", hz.sb_valid, 3'b000);
      chk("rst_stall", hz.stall, 1'b0);
      chk("rst_stall_cnt", hz.stall_cnt, 32'd0);
      @(negedge clk); rst = 1'b0;
      drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00);

      // counter saturation
      @(negedge clk);
      force dut.stallCnt = 32'hFFFF_FFFE;
      #1 release dut.stallCnt;
      #1;
      chk("sat_preload", hz.stall_cnt, 32'hFFFF_FFFE);
      for (int i = 0; i < 3; i++) begin
         @(negedge clk); drive(1'b1, 5'd5, 1'b1, 1'b1, 1'b0, 5'd0, 5'd0, 2'b00);
         @(negedge clk); drive(1'b1, 5'd9, 1'b1, 1'b0, 1'b0, 5'd5, 5'd0, 2'b11); #1;
         chk("sat_stall", hz.stall, 1'b1);
         @(negedge clk); drive(1'b0, 5'd0, 1'b0, 1'b0, 1'b0, 5'd0, 5'd0, 2'b00); #1;
         chk("sat_cnt", hz.stall_cnt, 32'hFFFF_FFFF);
      end

      $display("Result: errors=%0d of %0d checks", nErr, nChk);
      $finish;
   end
endmodule
